// File: rtl/stream_axi_pkg.sv
// Shared constants for the stream-encoded AXI address channel: type tags,
// fixed burst/cache attributes and the presenter FSM state type.
package stream_axi_pkg;
  localparam int STREAM_TYPE_W = 3;
  localparam logic [STREAM_TYPE_W-1:0] STREAM_TYPE_AR = 3'b000;
  localparam logic [STREAM_TYPE_W-1:0] STREAM_TYPE_AW = 3'b001;

  localparam logic [1:0] AXBURST_INCR    = 2'b01;
  localparam logic [3:0] AXCACHE_MOD_BUF = 4'b0011;

  typedef enum logic {AX_IDLE, AX_PRESENT} ax_state_e;
endpackage

// File: rtl/ax_cmd_fifo.sv
// Single-clock command buffer; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module ax_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/stream_to_axi_ax.sv
// Decodes Ax commands carried on a stream, buffers them, and replays them
// on an AXI4 AR/AW master at up to one command per cycle.
module stream_to_axi_ax
  import stream_axi_pkg::*;
#(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ADDR_WIDTH        = 64,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           BURST_LEN         = 8,
  parameter int                           LOCK_WIDTH        = 2,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = STREAM_TYPE_W,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = STREAM_TYPE_AR,
  parameter int                           FIFO_DEPTH        = 4,
  parameter logic [2:0]                   AXSIZE            = 3'b100
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [DATA_WIDTH-1:0]           s_tdata,
  input  logic                            s_tvalid,
  input  logic                            s_tlast,
  output logic                            s_tready,
  input  logic                            enable,
  output logic [ID_WIDTH-1:0]             AXIM_axid,
  output logic [ADDR_WIDTH-1:0]           AXIM_axaddr,
  output logic [BURST_LEN-1:0]            AXIM_axlen,
  output logic [2:0]                      AXIM_axsize,
  output logic [1:0]                      AXIM_axburst,
  output logic [LOCK_WIDTH-1:0]           AXIM_axlock,
  output logic [3:0]                      AXIM_axcache,
  output logic [2:0]                      AXIM_axprot,
  output logic [3:0]                      AXIM_axregion,
  output logic [3:0]                      AXIM_axqos,
  output logic [USER_WIDTH-1:0]           AXIM_axuser,
  output logic                            AXIM_axvalid,
  input  logic                            AXIM_axready,
  output logic [15:0]                     drop_count,
  output logic [31:0]                     issued_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [BURST_LEN-1:0]  len;
    logic [ADDR_WIDTH-1:0] addr;
  } ax_cmd_t;

  localparam int ID_MSB  = DATA_WIDTH - STREAM_TYPE_WIDTH - 1;
  localparam int LEN_MSB = ID_MSB - ID_WIDTH;

  ax_cmd_t                      beat_cmd, head_cmd, cmd_q;
  logic [STREAM_TYPE_WIDTH-1:0] beat_type;
  logic                         accept, beat_ok, push, pop, fire;
  logic                         fifo_full, fifo_empty;
  ax_state_e                    state_q, state_d;
  logic [15:0]                  drop_q, drop_d;
  logic [31:0]                  issued_q, issued_d;
  logic                         unused_tdata;

  // Bits between len and addr carry nothing for us.
  assign unused_tdata = ^s_tdata;

  assign beat_type     = s_tdata[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
  assign beat_cmd.id   = s_tdata[ID_MSB -: ID_WIDTH];
  assign beat_cmd.len  = s_tdata[LEN_MSB -: BURST_LEN];
  assign beat_cmd.addr = s_tdata[ADDR_WIDTH-1:0];

  assign s_tready = resetn & ~fifo_full;
  assign accept   = s_tvalid & s_tready;
  assign beat_ok  = (beat_type == STREAM_TYPE) & s_tlast;
  assign push     = accept & beat_ok;

  ax_cmd_fifo #(
    .WIDTH ($bits(ax_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .wdata_i (beat_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign AXIM_axvalid = (state_q == AX_PRESENT);
  assign fire         = AXIM_axvalid & AXIM_axready;

  // enable only gates loading a new command; a presented one stays until taken.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      AX_IDLE: begin
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          state_d = AX_PRESENT;
        end
      end
      AX_PRESENT: begin
        if (AXIM_axready) begin
          if (enable && !fifo_empty) pop = 1'b1;
          else                       state_d = AX_IDLE;
        end
      end
      default: state_d = AX_IDLE;
    endcase
  end

  always_comb begin
    drop_d   = drop_q;
    issued_d = issued_q;
    if (accept && !beat_ok && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    if (fire) issued_d = issued_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= AX_IDLE;
      cmd_q    <= '0;
      drop_q   <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      issued_q <= issued_d;
      if (pop) cmd_q <= head_cmd;
    end
  end

  assign AXIM_axid     = cmd_q.id;
  assign AXIM_axlen    = cmd_q.len;
  assign AXIM_axaddr   = cmd_q.addr;
  // Constant attributes still read as zero while held in reset.
  assign AXIM_axsize   = resetn ? AXSIZE          : 3'b000;
  assign AXIM_axburst  = resetn ? AXBURST_INCR    : 2'b00;
  assign AXIM_axcache  = resetn ? AXCACHE_MOD_BUF : 4'b0000;
  assign AXIM_axlock   = '0;
  assign AXIM_axprot   = '0;
  assign AXIM_axregion = '0;
  assign AXIM_axqos    = '0;
  assign AXIM_axuser   = '0;

  assign drop_count   = drop_q;
  assign issued_count = issued_q;
endmodule

// File: tb/tb_stream_to_axi_ax.sv
// Directed bench for stream_to_axi_ax: a queue/slot model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_stream_to_axi_ax;
  localparam int DW = 128, AW = 64, IW = 32, BL = 8, DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, enable = 1'b1, AXIM_axready = 1'b1;
  logic          s_tready, AXIM_axvalid;
  logic [IW-1:0] AXIM_axid;
  logic [AW-1:0] AXIM_axaddr;
  logic [BL-1:0] AXIM_axlen;
  logic [2:0]    AXIM_axsize, AXIM_axprot;
  logic [1:0]    AXIM_axburst, AXIM_axlock;
  logic [3:0]    AXIM_axcache, AXIM_axregion, AXIM_axqos;
  logic [63:0]   AXIM_axuser;
  logic [15:0]   drop_count;
  logic [31:0]   issued_count;
  logic [2:0]    fifo_level;

  stream_to_axi_ax dut (
    .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .enable(enable),
    .AXIM_axid(AXIM_axid), .AXIM_axaddr(AXIM_axaddr), .AXIM_axlen(AXIM_axlen),
    .AXIM_axsize(AXIM_axsize), .AXIM_axburst(AXIM_axburst), .AXIM_axlock(AXIM_axlock),
    .AXIM_axcache(AXIM_axcache), .AXIM_axprot(AXIM_axprot), .AXIM_axregion(AXIM_axregion),
    .AXIM_axqos(AXIM_axqos), .AXIM_axuser(AXIM_axuser), .AXIM_axvalid(AXIM_axvalid),
    .AXIM_axready(AXIM_axready), .drop_count(drop_count), .issued_count(issued_count),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of buffered commands plus one "presented" slot.
  typedef struct packed {
    logic [IW-1:0] id;
    logic [BL-1:0] len;
    logic [AW-1:0] addr;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        m_pc = '0, m_nc;
  logic        m_pv = 1'b0, m_hs, m_full;
  int unsigned m_drop = 0;
  logic [31:0] m_iss = '0;
  logic [IW-1:0] got[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_pv = 1'b0;
      m_drop = 0;
      m_iss = '0;
    end else begin
      m_hs   = m_pv && AXIM_axready;
      m_full = (mq.size() >= DEPTH);
      if (m_hs) begin
        m_iss = m_iss + 32'd1;
        got.push_back(m_pc.id);
      end
      if ((!m_pv || m_hs) && enable && mq.size() > 0) begin
        m_pc = mq.pop_front();
        m_pv = 1'b1;
      end else if (m_hs) m_pv = 1'b0;
      if (s_tvalid && !m_full) begin
        m_nc.id   = s_tdata[DW-4 -: IW];
        m_nc.len  = s_tdata[DW-4-IW -: BL];
        m_nc.addr = s_tdata[AW-1:0];
        if (s_tdata[DW-1 -: 3] == 3'b000 && s_tlast) mq.push_back(m_nc);
        else if (m_drop < 65535) m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    chk("s_tready", s_tready, resetn && mq.size() < DEPTH);
    chk("axvalid", AXIM_axvalid, m_pv);
    if (m_pv) begin
      chk("axid", AXIM_axid, m_pc.id);
      chk("axlen", AXIM_axlen, m_pc.len);
      chk("axaddr", AXIM_axaddr, m_pc.addr);
      chk("axsize", AXIM_axsize, 3'b100);
      chk("axburst", AXIM_axburst, 2'b01);
      chk("axcache", AXIM_axcache, 4'b0011);
      chk("axzero", {AXIM_axlock, AXIM_axprot, AXIM_axregion, AXIM_axqos, AXIM_axuser}, '0);
    end
    chk("fifo_level", fifo_level, mq.size());
    chk("drop_count", drop_count, m_drop);
    chk("issued_count", issued_count, m_iss);
  end

  function automatic logic [DW-1:0] beat(input logic [2:0] t, input logic [IW-1:0] id,
                                          input logic [BL-1:0] len, input logic [AW-1:0] addr);
    logic [DW-1:0] b;
    b = '0;
    b[84:64]         = 21'h15A5A5;  // junk in the ignored gap
    b[DW-1 -: 3]     = t;
    b[DW-4 -: IW]    = id;
    b[DW-4-IW -: BL] = len;
    b[AW-1:0]        = addr;
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] b, input logic last);
    int n;
    n = 0;
    s_tdata = b; s_tvalid = 1'b1; s_tlast = last;
    while (!s_tready && n < 200) begin step(1); n++; end
    if (n == 200) chk("send_timeout", 1'b1, 1'b0);
    step(1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  initial begin
    int base, n;
    #1 resetn = 1'b0;
    step(2);
    chk("rst_axvalid", AXIM_axvalid, 1'b0);
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_fields", {AXIM_axid, AXIM_axaddr, AXIM_axlen, AXIM_axsize, AXIM_axburst, AXIM_axcache}, '0);
    chk("rst_counts", {drop_count, issued_count, fifo_level}, '0);
    resetn = 1'b1;
    step(1);

    // Single good beat: presented one edge after acceptance, then taken.
    send(beat(3'b000, 32'd5, 8'd3, 64'h1000), 1'b1);
    step(1);
    chk("t1_axvalid", AXIM_axvalid, 1'b1);
    chk("t1_cmd", {AXIM_axid, AXIM_axlen, AXIM_axaddr}, {32'd5, 8'd3, 64'h1000});
    step(1);
    chk("t1_issued", issued_count, 32'd1);
    chk("t1_idle", AXIM_axvalid, 1'b0);

    // Wrong type, then missing tlast.
    send(beat(3'b010, 32'd6, 8'd1, 64'h2000), 1'b1);
    step(3);
    chk("t2_drop1", drop_count, 16'd1);
    chk("t2_novalid", AXIM_axvalid, 1'b0);
    send(beat(3'b000, 32'd7, 8'd1, 64'h3000), 1'b0);
    step(3);
    chk("t2_drop2", drop_count, 16'd2);

    // Backpressure: one held in the output regs plus four buffered.
    AXIM_axready = 1'b0;
    base = got.size();
    for (int i = 0; i < 5; i++) send(beat(3'b000, 32'(10 + i), 8'(i), 64'h4000 + 64'(i * 'h40)), 1'b1);
    chk("t3_full_tready", s_tready, 1'b0);
    chk("t3_level", fifo_level, 3'd4);
    s_tdata = beat(3'b000, 32'd99, 8'd0, 64'h0); s_tvalid = 1'b1; s_tlast = 1'b1;
    step(3);
    s_tvalid = 1'b0;
    chk("t3_held_id", AXIM_axid, 32'd10);
    AXIM_axready = 1'b1;
    n = 0;
    while (got.size() < base + 5 && n < 50) begin step(1); n++; end
    chk("t3_count", got.size() - base, 5);
    for (int i = 0; i < 5 && base + i < got.size(); i++) chk("t3_order", got[base + i], 32'(10 + i));
    step(2);

    // enable low while presenting must not disturb the presented command.
    AXIM_axready = 1'b0;
    send(beat(3'b000, 32'd20, 8'd2, 64'hA000), 1'b1);
    step(1);
    enable = 1'b0;
    send(beat(3'b000, 32'd21, 8'd4, 64'hB000), 1'b1);
    step(2);
    chk("t4_stable_v", AXIM_axvalid, 1'b1);
    chk("t4_stable_cmd", {AXIM_axid, AXIM_axlen, AXIM_axaddr}, {32'd20, 8'd2, 64'hA000});
    AXIM_axready = 1'b1;
    step(1);
    chk("t4_idle_dis", AXIM_axvalid, 1'b0);
    chk("t4_queued", fifo_level, 3'd1);
    enable = 1'b1;
    step(1);
    chk("t4_next_id", AXIM_axid, 32'd21);
    step(2);

    // Reset while presenting with two queued.
    AXIM_axready = 1'b0;
    for (int i = 0; i < 3; i++) send(beat(3'b000, 32'(30 + i), 8'd0, 64'hC000), 1'b1);
    step(1);
    chk("t5_pre_level", fifo_level, 3'd2);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_valid", AXIM_axvalid, 1'b0);
    chk("t5_rst_counts", {drop_count, issued_count, fifo_level}, '0);
    step(2);
    resetn = 1'b1;
    AXIM_axready = 1'b1;
    base = got.size();
    step(10);
    chk("t5_no_emit", got.size(), base);
    chk("t5_no_valid", AXIM_axvalid, 1'b0);

    // Drive drop_count to saturation with continuous bad beats.
    s_tdata = beat(3'b111, 32'd1, 8'd1, 64'h0); s_tlast = 1'b1; s_tvalid = 1'b1;
    step(65535);
    s_tvalid = 1'b0;
    chk("t6_sat", drop_count, 16'hFFFF);
    send(beat(3'b000, 32'd1, 8'd1, 64'h0), 1'b0);
    send(beat(3'b101, 32'd1, 8'd1, 64'h0), 1'b1);
    step(1);
    chk("t6_stay", drop_count, 16'hFFFF);
    send(beat(3'b000, 32'd44, 8'd8, 64'hD000), 1'b1);
    step(3);
    chk("t6_good_after", got[got.size() - 1], 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
